// File: rtl/iic_pkg.sv
// Shared I2C definitions for the iic master/slave pair.
//   iic_state_e   : responder state machine states
//   IicDevAddr    : default 7-bit device address of the on-board EEPROM model
//   IicWrite/Read : encoding of the R/W bit that follows the device address
package iic_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StDevAddr,
    StAckDev,
    StWordAddr,
    StAckWord,
    StWrData,
    StAckWr,
    StRdData,
    StRdAck
  } iic_state_e;

  localparam logic [6:0] IicDevAddr = 7'h50;
  localparam logic       IicWrite   = 1'b0;
  localparam logic       IicRead    = 1'b1;

endpackage

// File: rtl/iic_bus_sync.sv
// Synchronises scl/sda into the clk domain and derives single-clk event pulses.
//   clk, rst  : system clock, asynchronous active-high reset
//   scl, sda  : raw bus levels
//   sda_s     : synchronised sda level
//   scl_rise  : synchronised scl rising edge
//   scl_fall  : synchronised scl falling edge
//   start_det : sda fell while scl high
//   stop_det  : sda rose while scl high
module iic_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] metastability stage, [1] synchronised level, [2] previous level
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Reset to the idle-bus level so leaving reset does not fake an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/iic_slave.sv
// I2C responder modelling a small serial EEPROM with an auto-incrementing word pointer.
//   clk, rst  : system clock (>= 20x scl), asynchronous active-high reset
//   scl       : bus clock from the master (never stretched)
//   sda       : open-drain data, only pulled low or released
//   wr_data   : last byte committed to the array
//   wr_strobe : one-clk pulse per committed byte
//   busy      : high from an address-matched START until STOP or read NACK
module iic_slave
  import iic_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = IicDevAddr,
  parameter int unsigned MEM_AW   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  output logic       busy
);

  localparam int unsigned Depth = 2 ** MEM_AW;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  iic_bus_sync u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  iic_state_e        state_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic              got_q;      // byte fully shifted in / master ACK seen
  logic              rw_q;
  logic [MEM_AW-1:0] ptr_q;
  logic              sda_oe_q;
  logic [7:0]        mem_q [Depth];
  logic [MEM_AW-1:0] ptr_inc;
  logic              rx_state;

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign ptr_inc  = ptr_q + 1'b1;
  assign rx_state = (state_q == StDevAddr) || (state_q == StWordAddr) || (state_q == StWrData);

  // Bits are taken on scl_rise; every drive change waits for scl_fall so sda only moves
  // while scl is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd7;
      got_q     <= 1'b0;
      rw_q      <= IicWrite;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      wr_data   <= 8'h00;
      wr_strobe <= 1'b0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state_q   <= StDevAddr;
        bit_cnt_q <= 3'd7;
        got_q     <= 1'b0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q  <= StIdle;
        got_q    <= 1'b0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else begin
        if (rx_state && scl_rise && !got_q) begin
          shift_q <= {shift_q[6:0], sda_s};
          if (bit_cnt_q == 3'd0) got_q <= 1'b1;
          else bit_cnt_q <= bit_cnt_q - 1'b1;
        end
        unique case (state_q)
          StDevAddr: begin
            if (scl_fall && got_q) begin
              got_q <= 1'b0;
              if (shift_q[7:1] == DEV_ADDR) begin
                state_q  <= StAckDev;
                rw_q     <= shift_q[0];
                busy     <= 1'b1;
                sda_oe_q <= 1'b1;
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end
            end
          end
          StAckDev: begin
            if (scl_fall) begin
              bit_cnt_q <= 3'd7;
              if (rw_q == IicRead) begin
                state_q  <= StRdData;
                shift_q  <= mem_q[ptr_q];
                sda_oe_q <= ~mem_q[ptr_q][7];
              end else begin
                state_q  <= StWordAddr;
                sda_oe_q <= 1'b0;
              end
            end
          end
          StWordAddr: begin
            if (scl_fall && got_q) begin
              got_q    <= 1'b0;
              ptr_q    <= shift_q[MEM_AW-1:0];
              state_q  <= StAckWord;
              sda_oe_q <= 1'b1;
            end
          end
          StWrData: begin
            if (scl_fall && got_q) begin
              got_q         <= 1'b0;
              mem_q[ptr_q]  <= shift_q;
              wr_data       <= shift_q;
              wr_strobe     <= 1'b1;
              ptr_q         <= ptr_inc;
              state_q       <= StAckWr;
              sda_oe_q      <= 1'b1;
            end
          end
          StAckWord, StAckWr: begin
            if (scl_fall) begin
              state_q   <= StWrData;
              bit_cnt_q <= 3'd7;
              sda_oe_q  <= 1'b0;
            end
          end
          StRdData: begin
            if (scl_fall) begin
              if (bit_cnt_q == 3'd0) begin
                state_q  <= StRdAck;
                sda_oe_q <= 1'b0;
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
                shift_q   <= {shift_q[6:0], 1'b0};
                sda_oe_q  <= ~shift_q[6];
              end
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              if (sda_s) begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end else begin
                got_q <= 1'b1;
                ptr_q <= ptr_inc;
              end
            end else if (scl_fall && got_q) begin
              // ptr_q already advanced on the ACK rise
              got_q     <= 1'b0;
              state_q   <= StRdData;
              bit_cnt_q <= 3'd7;
              shift_q   <= mem_q[ptr_q];
              sda_oe_q  <= ~mem_q[ptr_q][7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_slave.sv
module tb_iic_slave;

  localparam int         Q       = 60;  // quarter scl period: 6 clks
  localparam int         Depth   = 8;
  localparam logic [6:0] DevAddr = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;  // master pulls sda low
  wire        sda;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  iic_slave dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .wr_data   (wr_data),
    .wr_strobe (wr_strobe),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  // Reference model: byte array plus word pointer
  logic [7:0] m_mem [Depth];
  int         m_ptr;
  logic [7:0] wq [$];

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    m_low = 1'b0; #Q scl = 1'b1; #Q m_low = 1'b1; #Q scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q scl = 1'b1; #Q m_low = 1'b0; #Q;
  endtask

  // stray flags a low bus on a bit the master left released
  task automatic write_byte(input logic [7:0] b, output logic ack, output logic stray);
    stray = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i];
      #Q scl = 1'b1;
      #Q if (b[i] && sda !== 1'b1) stray = 1'b1;
      #Q scl = 1'b0;
      #Q;
    end
    m_low = 1'b0;
    #Q scl = 1'b1;
    #Q ack = (sda === 1'b0);
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q scl = 1'b1;
      #Q b[i] = (sda !== 1'b0);
      #Q scl = 1'b0;
      #Q;
    end
    m_low = ack;
    #Q scl = 1'b1;
    #(2 * Q) scl = 1'b0;
    #Q;
  endtask

  task automatic do_write(input logic [7:0] word);
    logic ack, stray;
    int   s0;
    s0 = strobe_cnt;
    bus_start();
    write_byte({DevAddr, 1'b0}, ack, stray);
    check("wr dev ack", ack, 1);
    check("busy after dev ack", busy, 1);
    write_byte(word, ack, stray);
    check("word ack", ack, 1);
    m_ptr = word % Depth;
    foreach (wq[k]) begin
      write_byte(wq[k], ack, stray);
      check("data ack", ack, 1);
      check("no stray drive", stray, 0);
      m_mem[m_ptr] = wq[k];
      m_ptr = (m_ptr + 1) % Depth;
    end
    bus_stop();
    check("wr_data", wr_data, wq[wq.size()-1]);
    check("strobe count", strobe_cnt - s0, wq.size());
    check("busy after stop", busy, 0);
    check("sda idle", sda, 1);
  endtask

  task automatic do_read(input logic set_addr, input logic [7:0] word, input int n);
    logic       ack, stray;
    logic [7:0] b;
    if (set_addr) begin
      bus_start();
      write_byte({DevAddr, 1'b0}, ack, stray);
      check("rd setup dev ack", ack, 1);
      write_byte(word, ack, stray);
      check("rd setup word ack", ack, 1);
      m_ptr = word % Depth;
    end
    bus_start();
    write_byte({DevAddr, 1'b1}, ack, stray);
    check("rd dev ack", ack, 1);
    for (int k = 0; k < n; k++) begin
      read_byte(b, k < n - 1);
      check("rd data", b, m_mem[m_ptr]);
      if (k < n - 1) m_ptr = (m_ptr + 1) % Depth;
    end
    check("busy after nack", busy, 0);
    check("sda released after nack", sda, 1);
    bus_stop();
    check("sda idle after rd", sda, 1);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic       exp_ack;
  } dev_vec_t;

  dev_vec_t dev_tab [7];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ack, stray;
    int   s0, op, n;
    dev_tab[0] = '{8'hA0, 1'b1};
    dev_tab[1] = '{8'hA1, 1'b1};
    dev_tab[2] = '{8'hA4, 1'b0};
    dev_tab[3] = '{8'hA2, 1'b0};
    dev_tab[4] = '{8'h50, 1'b0};
    dev_tab[5] = '{8'h21, 1'b0};
    dev_tab[6] = '{8'hE0, 1'b0};
    model_reset();

    #103;
    check("reset sda", sda, 1);
    check("reset wr_data", wr_data, 8'h00);
    check("reset wr_strobe", wr_strobe, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    #Q;

    // single write then random read of the same word
    wq.delete(); wq.push_back(8'h69);
    do_write(8'h03);
    do_read(1'b1, 8'h03, 1);

    // device address matching
    for (int i = 0; i < 7; i++) begin
      bus_start();
      write_byte(dev_tab[i].dev, ack, stray);
      check("dev table ack", ack, dev_tab[i].exp_ack);
      check("dev table busy", busy, dev_tab[i].exp_ack);
      if (dev_tab[i].exp_ack && dev_tab[i].dev[0]) begin
        logic [7:0] b;
        read_byte(b, 1'b0);
        check("dev table rd data", b, m_mem[m_ptr]);
      end else if (!dev_tab[i].exp_ack) begin
        write_byte(8'hFF, ack, stray);
        check("unaddressed no ack", ack, 0);
        check("unaddressed no drive", stray, 0);
        check("unaddressed busy", busy, 0);
      end
      bus_stop();
      check("dev table busy after stop", busy, 0);
    end

    // sequential write wrapping past the top word, then read back across the wrap
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
    do_write(8'h06);
    do_read(1'b1, 8'h06, 3);
    check("wrap mem0", m_mem[0], 8'h33);

    // STOP after 4 data bits: nothing committed, pointer kept
    s0 = strobe_cnt;
    bus_start();
    write_byte({DevAddr, 1'b0}, ack, stray);
    check("abort dev ack", ack, 1);
    write_byte(8'hF5, ack, stray);
    check("abort word ack", ack, 1);
    m_ptr = 5;
    for (int i = 0; i < 4; i++) begin
      m_low = 1'b0; #Q scl = 1'b1; #(2 * Q) scl = 1'b0; #Q;
    end
    bus_stop();
    check("abort no strobe", strobe_cnt - s0, 0);
    check("abort busy", busy, 0);
    do_read(1'b0, 8'h00, 1);

    // reset while the slave drives a 0 data bit
    wq.delete(); wq.push_back(8'h35);
    do_write(8'h02);
    bus_start();
    write_byte({DevAddr, 1'b0}, ack, stray);
    write_byte(8'h02, ack, stray);
    bus_start();
    write_byte({DevAddr, 1'b1}, ack, stray);
    check("pre-reset rd ack", ack, 1);
    check("slave drives 0 bit", sda, 0);
    rst = 1'b1;
    #1 check("sda released by reset", sda, 1);
    #Q scl = 1'b1;
    #Q check("busy in reset", busy, 0);
    check("wr_data in reset", wr_data, 8'h00);
    rst = 1'b0;
    model_reset();
    #Q;
    do_read(1'b1, 8'h02, 1);
    wq.delete(); wq.push_back(8'hC7);
    do_write(8'h04);
    do_read(1'b1, 8'h03, 2);

    // randomized traffic against the model
    for (int t = 0; t < 20; t++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        wq.delete();
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
        do_write(8'($urandom));
      end else if (op == 1) begin
        do_read(1'b1, 8'($urandom), $urandom_range(1, 4));
      end else begin
        do_read(1'b0, 8'h00, $urandom_range(1, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_slave.md
Name: iic_slave

Overview:
- I2C target (responder) model of a small serial EEPROM, for the address/data byte protocol our iic master drives.
- Sits on the same scl/sda bus as the master. Used in on-board loopback and simulation, so the master's key_wr/key_rd transactions complete without an external EEPROM.
- Holds a byte-addressable register array, ACKs its device address, and supports random/sequential write and read.
- Exposes the last written byte for display on seg7.

Parameters:
- DEV_ADDR, 7'h50, 7-bit device address matched against the first byte after START.
- MEM_AW, 3, register array address width (depth = 2**MEM_AW bytes).

Ports:
- clk  input  1  system clock; scl/sda are oversampled on it (clk ≥ 20× scl).
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  I2C clock from master; never stretched by this block.
- sda  inout  1  open-drain data; driven 1'b0 or released to 1'bz only.
- wr_data  output  8  last byte written into the array.
- wr_strobe  output  1  one-clk pulse each time a data byte is committed.
- busy  output  1  high from an address-matched START until STOP.

Behaviour:
- One clock domain; asynchronous, active-high reset.
- Reset values:
  - sda released (z); wr_data = 8'h00; wr_strobe = 0; busy = 0.
  - State IDLE; all array bytes 8'h00; word pointer 0.
- Synchronisation: scl and sda each pass a 2-FF synchroniser plus a history register. Edge and condition flags are single-clk pulses:
  - scl_rise / scl_fall: edges of synchronised scl.
  - START: synchronised sda falls while scl high.
  - STOP: synchronised sda rises while scl high.
- Bit timing: input bits are sampled on scl_rise. Any change to the sda drive happens on the clk after scl_fall, never while scl is high.
- Bit counter: 3 bits, MSB first, loaded 7 at each byte start.
- State machine:
  - IDLE: wait for START → DEVADDR.
  - DEVADDR: shift 8 bits. If bits[7:1] == DEV_ADDR → ACK_DEV, remember R/W bit. On mismatch → IDLE, no ACK.
  - ACK_DEV: hold sda low for the 9th scl period. Then W → WORDADDR; R → RD_DATA.
  - WORDADDR: shift 8 bits; pointer = byte[MEM_AW-1:0]; upper bits ignored. → ACK_WORD.
  - ACK_WORD: ACK → WR_DATA.
  - WR_DATA: shift 8 bits; → ACK_WR.
  - ACK_WR: ACK. On entry, commit the byte to array[pointer], wr_data ← byte, wr_strobe pulses 1 clk, pointer++. → WR_DATA.
  - RD_DATA: drive array[pointer] MSB first (drive low for 0, release for 1). → RD_ACK after 8 bits.
  - RD_ACK: release sda and sample the master's bit on scl_rise. Low (ACK) → pointer++, RD_DATA. High (NACK) → IDLE.
- Pointer wraps from 2**MEM_AW-1 to 0 on both write and read.
- STOP in any state → IDLE, sda released, busy = 0, pointer retained. A partial byte is discarded and never committed.
- START in any state (repeated start) → DEVADDR, bit counter reloaded, pointer retained. This gives random read: write word address, then Sr, then read.
- START and STOP cannot coincide. If a START and a scl edge flag occur in the same clk, START wins.
- busy rises on the clk ACK_DEV is entered and falls on STOP or on NACK → IDLE.
- Reset mid-transfer: immediate return to reset values, sda released that same cycle (asynchronous).

Decomposition:
- Package iic_pkg:
  - State enumeration (IDLE, DEVADDR, ACK_DEV, WORDADDR, ACK_WORD, WR_DATA, ACK_WR, RD_DATA, RD_ACK).
  - Default DEV_ADDR constant 7'h50 and the R/W bit encoding (0 = write), shared with the master.
- Sub-module iic_bus_sync: synchronisers plus scl_rise, scl_fall, START and STOP pulse generation.
- The FSM, shift register, pointer and array stay in iic_slave.

Test Plan:
- Single write: START, 8'hA0, 8'h03, 8'h69, STOP.
  - Three ACKs (sda low in each 9th clock).
  - wr_strobe pulses once; wr_data = 8'h69; array[3] = 8'h69; busy returns 0 after STOP.
- Random read: START, 8'hA0, 8'h03, Sr, 8'hA1, read 1 byte, master NACK, STOP.
  - sda bits read 0110_1001 (8'h69); sda released after NACK; FSM in IDLE.
- Wrong address: START, 8'hA4.
  - No ACK (sda stays z in 9th clock); no further drive until next START; busy stays 0.
- Sequential write with wrap: pointer 8'h06, data 8'h11, 8'h22, 8'h33.
  - array[6] = 11, array[7] = 22, array[0] = 33; three wr_strobe pulses.
  - Then a sequential read from 6 with ACK, ACK, NACK returns 11, 22, 33.
- Abort: STOP after 4 bits of a data byte → no commit, array unchanged, IDLE.
- Reset: assert rst while driving a read 0-bit → sda released that clk; after release, array all 8'h00 and the next transaction behaves normally.
